uart: RTL and testbench

// - Memory-mapped, transmit-only 8N1 UART peripheral for the 6809 computer CPLD.
// - Two registers are selected by ADDR: transmit data and status. Active-low R/W strobes are decoded from RW/E.
// - Top level instantiates two copies, at $C000 and $C100. Their TXD pins drive the serial outputs.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_shifter.sv | 100 ++++++++++
 rtl/uart.sv | 166 ++++++++++++++++
 tb/tb_uart.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the transmit-only 8N1 UART: register map, status bit
// positions, frame geometry and shifter state encodings.
package uart_pkg;

    localparam logic [0:0] REG_TXDATA = 1'b0;
    localparam logic [0:0] REG_STATUS = 1'b1;

    localparam int ST_READY = 0;
    localparam int ST_BUSY  = 1;
    localparam int ST_OVR   = 2;

    localparam int FRAME_BITS = 10;

    localparam logic [0:0] SH_IDLE   = 1'b0;
    localparam logic [0:0] SH_ACTIVE = 1'b1;

    typedef logic [3:0] bitcnt_t;

    // Start bit in the LSB so the frame can be shifted out right-first.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
        return {1'b1, data, 1'b0};
    endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// Serialiser: baud counter, bit counter, 10-bit shift register and the
// registered TXD line. Accepts a new load in the cycle the stop bit ends.
module uart_tx_shifter
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 104
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       txd_o
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_RELOAD = CW'(BAUD_DIV - 1);
    localparam bitcnt_t LAST_BIT = bitcnt_t'(FRAME_BITS - 1);

    logic [0:0]            state_q, state_d;
    logic [CW-1:0]         baud_q, baud_d;
    bitcnt_t               bit_q, bit_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  txd_q, txd_d;
    logic                  bit_end_s;
    logic                  done_s;

    assign bit_end_s = (state_q == SH_ACTIVE) && (baud_q == {CW{1'b0}});
    assign done_s    = bit_end_s && (bit_q == LAST_BIT);

    // Next-state logic for the serialiser.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        case (state_q)
            SH_IDLE: begin
                if (load_i) begin
                    state_d = SH_ACTIVE;
                    shift_d = build_frame(data_i);
                    txd_d   = 1'b0;
                    baud_d  = BAUD_RELOAD;
                    bit_d   = 4'd0;
                end else begin
                    txd_d = 1'b1;
                end
            end
            SH_ACTIVE: begin
                if (done_s) begin
                    // A load here chains the next frame with no idle cycle.
                    if (load_i) begin
                        shift_d = build_frame(data_i);
                        txd_d   = 1'b0;
                        baud_d  = BAUD_RELOAD;
                        bit_d   = 4'd0;
                    end else begin
                        state_d = SH_IDLE;
                        txd_d   = 1'b1;
                    end
                end else if (bit_end_s) begin
                    shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
                    txd_d   = shift_q[1];
                    baud_d  = BAUD_RELOAD;
                    bit_d   = bit_q + 4'd1;
                end else begin
                    baud_d = baud_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = SH_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    // Serialiser state registers; reset aborts any frame and idles TXD high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= SH_IDLE;
            baud_q  <= {CW{1'b0}};
            bit_q   <= 4'd0;
            shift_q <= {FRAME_BITS{1'b1}};
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    assign busy_o = (state_q == SH_ACTIVE);
    assign done_o = done_s;
    assign txd_o  = txd_q;

endmodule

// File: rtl/uart.sv
// Memory-mapped transmit-only 8N1 UART: strobe synchronisers, register
// decode, status and holding register. Define UART_TX_FIFO_EN for a TX FIFO.
module uart
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 104
`ifdef UART_TX_FIFO_EN
    ,
    parameter int FIFO_DEPTH = 4
`endif
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ADDR,
    inout  wire  [7:0] DATA,
    input  logic       W,
    input  logic       R,
    output logic       TXD
);

    logic [1:0] w_sync_q;
    logic       w_prev_q;
    logic [1:0] r_sync_q;
    logic       rd_stat_q, rd_stat_d;
    logic [7:0] hold_q, hold_d;
    logic       ovr_q, ovr_d;

    logic       write_evt_s;
    logic       wr_tx_s;
    logic       r_fall_s;
    logic       r_rise_s;
    logic       accept_s;
    logic       ready_s;
    logic       busy_s;
    logic       load_s;
    logic [7:0] load_data_s;
    logic       sh_busy_s;
    logic [7:0] status_s;
    logic [7:0] rd_data_s;

    assign write_evt_s = w_prev_q && !w_sync_q[1];
    assign wr_tx_s     = write_evt_s && (ADDR == REG_TXDATA);
    assign r_fall_s    = !r_sync_q[0] && r_sync_q[1];
    assign r_rise_s    = r_sync_q[0] && !r_sync_q[1];

`ifdef UART_TX_FIFO_EN
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] rd_nxt_s;
    logic [AW:0] count_s;
    logic        empty_s, full_s, sh_done_s, start_s, chain_s;

    // The head entry stays in the FIFO while it is on the wire; it is
    // popped when its stop bit ends, so a full FIFO still accepts then.
    assign count_s   = wr_ptr_q - rd_ptr_q;
    assign rd_nxt_s  = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    assign empty_s   = (count_s == {(AW+1){1'b0}});
    assign full_s    = (count_s == FULL_CNT);
    assign start_s   = !sh_busy_s && !empty_s;
    assign chain_s   = sh_done_s && (count_s > {{AW{1'b0}}, 1'b1});
    assign load_s    = start_s || chain_s;
    assign load_data_s = start_s ? mem_q[rd_ptr_q[AW-1:0]] : mem_q[rd_nxt_s[AW-1:0]];
    assign accept_s  = wr_tx_s && (!full_s || sh_done_s);
    assign ready_s   = !full_s;
    assign busy_s    = sh_busy_s || !empty_s;

    // FIFO storage and pointers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            if (accept_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= DATA;
                wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (sh_done_s) begin
                rd_ptr_q <= rd_nxt_s;
            end
        end
    end
`else
    assign accept_s    = wr_tx_s && ready_s;
    assign ready_s     = !sh_busy_s;
    assign busy_s      = sh_busy_s;
    assign load_s      = accept_s;
    assign load_data_s = DATA;
`endif

    uart_tx_shifter #(
        .BAUD_DIV (BAUD_DIV)
    ) u_shifter (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .load_i (load_s),
        .data_i (load_data_s),
        .busy_o (sh_busy_s),
`ifdef UART_TX_FIFO_EN
        .done_o (sh_done_s),
`else
        .done_o (),
`endif
        .txd_o  (TXD)
    );

    // Register next-state: holding register, status-read tracking, overrun.
    always_comb begin
        hold_d = wr_tx_s ? DATA : hold_q;
        if (r_fall_s) begin
            rd_stat_d = (ADDR == REG_STATUS);
        end else if (r_rise_s) begin
            rd_stat_d = 1'b0;
        end else begin
            rd_stat_d = rd_stat_q;
        end
        // A drop on the same edge as a status-read clear keeps OVERRUN set.
        if (wr_tx_s && !accept_s) begin
            ovr_d = 1'b1;
        end else if (r_rise_s && rd_stat_q) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // Strobe synchronisers and register state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            w_sync_q  <= 2'b11;
            w_prev_q  <= 1'b1;
            r_sync_q  <= 2'b11;
            rd_stat_q <= 1'b0;
            hold_q    <= 8'h00;
            ovr_q     <= 1'b0;
        end else begin
            w_sync_q  <= {w_sync_q[0], W};
            w_prev_q  <= w_sync_q[1];
            r_sync_q  <= {r_sync_q[0], R};
            rd_stat_q <= rd_stat_d;
            hold_q    <= hold_d;
            ovr_q     <= ovr_d;
        end
    end

    // Status word assembly and read mux.
    always_comb begin
        status_s           = 8'h00;
        status_s[ST_READY] = ready_s;
        status_s[ST_BUSY]  = busy_s;
        status_s[ST_OVR]   = ovr_q;
        if (ADDR == REG_STATUS) begin
            rd_data_s = status_s;
        end else begin
            rd_data_s = hold_q;
        end
    end

    assign DATA = (!R) ? rd_data_s : 8'hzz;

endmodule

// File: tb/tb_uart.sv
// Directed bench for uart with BAUD_DIV = 4: vector table plus hand-timed
// sequences for overrun, stop-bit boundary and mid-frame reset.
module tb_uart;

    localparam int BD = 4;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       ADDR = 1'b0;
    logic       W = 1'b1;
    logic       R = 1'b1;
    logic       TXD;
    logic [7:0] d_drv = 8'h00;
    logic       d_en = 1'b0;
    wire  [7:0] data_w;

    int n_checks = 0;
    int n_errors = 0;

    assign data_w = d_en ? d_drv : 8'hzz;

    uart #(.BAUD_DIV(BD)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .ADDR  (ADDR),
        .DATA  (data_w),
        .W     (W),
        .R     (R),
        .TXD   (TXD)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       a;
        logic [7:0] d;
        int         wlen;
        logic       frame;
        logic [7:0] exp_hold;
        logic [7:0] exp_mid;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic write_reg(input logic a, input logic [7:0] d, input int low);
        @(negedge CLK);
        ADDR = a; d_drv = d; d_en = 1'b1; W = 1'b0;
        repeat (low) @(negedge CLK);
        W = 1'b1;
        repeat (3) @(negedge CLK);
        d_en = 1'b0;
    endtask

    task automatic read_check(input logic a, input logic [7:0] exp, input string name);
        @(negedge CLK);
        ADDR = a; R = 1'b0;
        #1 check(name, data_w, exp);
        repeat (4) @(negedge CLK);
        R = 1'b1;
        repeat (3) @(negedge CLK);
    endtask

    // Waits up to max_wait cycles for a start bit, then checks each bit cycle by cycle.
    task automatic check_frame(input logic [7:0] d, input int max_wait, input string name);
        int   w = 0;
        logic eb;
        logic bad;
        @(negedge CLK);
        while (TXD !== 1'b0 && w < max_wait) begin
            @(negedge CLK);
            w++;
        end
        if (TXD !== 1'b0) begin
            check({name, "_start"}, {7'd0, TXD}, 8'h00);
            return;
        end
        for (int k = 0; k < 10; k++) begin
            eb  = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : d[k-1];
            bad = 1'b0;
            for (int c = 0; c < BD; c++) begin
                if (k != 0 || c != 0) @(negedge CLK);
                if (TXD !== eb) bad = 1'b1;
            end
            check($sformatf("%s_bit%0d", name, k), {7'd0, bad ? ~eb : eb}, {7'd0, eb});
        end
    endtask

    task automatic expect_idle(input int n, input string name);
        logic seen0 = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (TXD !== 1'b1) seen0 = 1'b1;
        end
        check(name, {7'd0, ~seen0}, 8'h01);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 8'h55, 4,  1'b1, 8'h55, 8'h02};
        vecs[1] = '{1'b0, 8'hA7, 4,  1'b1, 8'hA7, 8'h02};
        vecs[2] = '{1'b0, 8'h00, 3,  1'b1, 8'h00, 8'h02};
        vecs[3] = '{1'b0, 8'hFF, 3,  1'b1, 8'hFF, 8'h02};
        vecs[4] = '{1'b1, 8'h99, 4,  1'b0, 8'hFF, 8'h01};
        vecs[5] = '{1'b0, 8'h3C, 50, 1'b1, 8'h3C, 8'h01};

        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("reset_txd", {7'd0, TXD}, 8'h01);
        read_check(1'b1, 8'h01, "reset_status");
        read_check(1'b0, 8'h00, "reset_hold");

`ifdef UART_TX_FIFO_EN
        fork
            begin
                for (int i = 1; i <= 5; i++) write_reg(1'b0, 8'(i), 3);
                read_check(1'b1, 8'h06, "fifo_full_status");
            end
            begin
                check_frame(8'h01, 20, "fifo_f1");
                check_frame(8'h02, 0,  "fifo_f2");
                check_frame(8'h03, 0,  "fifo_f3");
                check_frame(8'h04, 0,  "fifo_f4");
                expect_idle(60, "fifo_no_f5");
            end
        join
        read_check(1'b1, 8'h01, "fifo_status_end");
`else
        for (int i = 0; i < 6; i++) begin
            fork
                begin
                    write_reg(vecs[i].a, vecs[i].d, vecs[i].wlen);
                    read_check(1'b0, vecs[i].exp_hold, $sformatf("v%0d_hold", i));
                    read_check(1'b1, vecs[i].exp_mid, $sformatf("v%0d_status_mid", i));
                end
                begin
                    if (vecs[i].frame) check_frame(vecs[i].d, 20, $sformatf("v%0d_frame", i));
                    expect_idle(60, $sformatf("v%0d_idle", i));
                end
            join
            read_check(1'b1, 8'h01, $sformatf("v%0d_status_end", i));
        end

        // Bus released while R is high: only the bench drives the bus.
        @(negedge CLK);
        d_drv = 8'h00; d_en = 1'b1;
        #1 check("bus_released", data_w, 8'h00);
        @(negedge CLK);
        d_en = 1'b0;

        // Second write mid-frame is dropped and raises OVERRUN.
        fork
            begin
                write_reg(1'b0, 8'h11, 4);
                write_reg(1'b0, 8'h22, 4);
                read_check(1'b1, 8'h06, "ovr_status");
            end
            begin
                check_frame(8'h11, 20, "ovr_frame");
                expect_idle(30, "ovr_no_22");
            end
        join
        read_check(1'b1, 8'h01, "ovr_cleared");
        read_check(1'b0, 8'h22, "ovr_hold_latched");

        // New overrun on the same edge as the status-read clear: set wins.
        fork
            begin
                write_reg(1'b0, 8'h44, 4);
                write_reg(1'b0, 8'h22, 4);
                @(negedge CLK);
                ADDR = 1'b1; R = 1'b0;
                #1 check("setwins_rd", data_w, 8'h06);
                repeat (4) @(negedge CLK);
                ADDR = 1'b0; W = 1'b0;
                @(negedge CLK);
                R = 1'b1; d_drv = 8'h33; d_en = 1'b1;
                repeat (3) @(negedge CLK);
                W = 1'b1;
                repeat (3) @(negedge CLK);
                d_en = 1'b0;
            end
            begin
                check_frame(8'h44, 20, "setwins_frame");
                expect_idle(30, "setwins_idle");
            end
        join
        read_check(1'b1, 8'h05, "setwins_ovr_kept");
        read_check(1'b1, 8'h01, "setwins_ovr_cleared");

        // Write landing on the stop-bit end edge is dropped; one cycle later is accepted.
        for (int off = 40; off <= 41; off++) begin
            fork
                begin
                    @(negedge CLK);
                    ADDR = 1'b0; d_drv = 8'h66; d_en = 1'b1; W = 1'b0;
                    repeat (4) @(negedge CLK);
                    W = 1'b1;
                    repeat (off - 4) @(negedge CLK);
                    d_drv = 8'h77; W = 1'b0;
                    repeat (4) @(negedge CLK);
                    W = 1'b1;
                    repeat (3) @(negedge CLK);
                    d_en = 1'b0;
                end
                begin
                    check_frame(8'h66, 20, $sformatf("edge%0d_frame", off));
                    if (off == 41) check_frame(8'h77, 1, "edge41_next");
                    expect_idle(20, $sformatf("edge%0d_idle", off));
                end
            join
            read_check(1'b1, (off == 40) ? 8'h05 : 8'h01, $sformatf("edge%0d_status", off));
            read_check(1'b1, 8'h01, $sformatf("edge%0d_status2", off));
        end
`endif

        // Reset during bit 3 aborts the frame immediately.
        fork
            write_reg(1'b0, 8'h5A, 4);
            begin
                int w = 0;
                @(negedge CLK);
                while (TXD !== 1'b0 && w < 20) begin
                    @(negedge CLK);
                    w++;
                end
                check("rst_frame_started", {7'd0, TXD}, 8'h00);
                repeat (13) @(negedge CLK);
                #2 RESET = 1'b1;
                #1 check("rst_txd_immediate", {7'd0, TXD}, 8'h01);
                @(negedge CLK);
                RESET = 1'b0;
            end
        join
        expect_idle(20, "rst_idle");
        read_check(1'b1, 8'h01, "rst_status");
        read_check(1'b0, 8'h00, "rst_hold");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
